// File: rtl/opb_register_simulink2ppc_snap.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// opb_register_simulink2ppc_snap
//
// Read-only OPB register bank that lets the PowerPC observe fabric data.
// A word presented on user_data_in is captured whenever user_valid is high
// and the freeze bit is clear; every capture also bumps a wrapping 32-bit
// counter. The processor reads the captured word, the counter and the freeze
// bit. The freeze bit is the only writable location.
//
// Register map (byte offsets from C_BASEADDR):
//   0x00 DATA  (RO)  last captured user_data_in
//   0x04 COUNT (RO)  number of accepted captures, wraps to 0
//   0x08 CTRL  (RW)  bit 0 = freeze, other bits read 0
//   0x0C..0xFC       read 0, writes ignored, still acknowledged
//
// Ports:
//   OPB_Clk                          shared OPB / user clock
//   OPB_Rst                          asynchronous active-high reset
//   OPB_ABus, OPB_BE, OPB_DBus       OPB address, byte enables, write data
//                                    (big-endian bit numbering, bit 0 = MSB)
//   OPB_RNW, OPB_select, OPB_seqAddr OPB control (seqAddr unused)
//   Sl_DBus, Sl_xferAck              read data and single-cycle acknowledge
//   Sl_errAck, Sl_retry, Sl_toutSup  tied low
//   user_data_in, user_valid         fabric capture port
// ---------------------------------------------------------------------------
module opb_register_simulink2ppc_snap #(
    parameter logic [31:0] C_BASEADDR   = 32'h0103C100,
    parameter logic [31:0] C_HIGHADDR   = 32'h0103C1FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex6"
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    output logic                        Sl_xferAck,
    input  logic [31:0]                 user_data_in,
    input  logic                        user_valid
);

    // Family is informational only.
    localparam bit unused_family = (C_FAMILY != "");

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [5:0] WORD_DATA  = 6'd0;
    localparam logic [5:0] WORD_COUNT = 6'd1;
    localparam logic [5:0] WORD_CTRL  = 6'd2;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] data_q;
    logic [31:0] count_q;
    logic        freeze_q;
    logic [31:0] rd_data_q;

    logic        addr_hit;
    logic        start;
    logic [5:0]  word_idx;
    logic [31:0] read_mux;
    logic        ctrl_wr;
    logic        capture;

    // Address bits, enables and data lanes that no register decodes.
    logic unused_inputs;
    assign unused_inputs = ^{OPB_seqAddr, OPB_ABus[30:31], OPB_BE[0:2], OPB_DBus[0:30]};

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign addr_hit = (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    assign word_idx = OPB_ABus[24:29];
    // Only the IDLE state accepts a new access, which is what limits the
    // bank to one acknowledge per select assertion.
    assign start    = (state_q == IDLE) && OPB_select && addr_hit;
    assign ctrl_wr  = start && !OPB_RNW && (word_idx == WORD_CTRL) && OPB_BE[3];
    // Uses the freeze value from before this edge, so a CTRL write landing
    // on the same edge only affects later captures.
    assign capture  = user_valid && !freeze_q;

    always_comb begin
        // NOTE: every variable written in a combinational block gets a
        // default first, so no path can leave it unassigned and infer a latch.
        read_mux = 32'h0;
        unique case (word_idx)
            WORD_DATA:  read_mux = data_q;
            WORD_COUNT: read_mux = count_q;
            WORD_CTRL:  read_mux = {31'h0, freeze_q};
            default:    read_mux = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (OPB_Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ACK;
            // The acknowledge lasts one cycle whatever select does.
            ACK:     state_d = WAIT;
            WAIT:    if (!OPB_select) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (decoded from registered state, so they drop the
    // instant the asynchronous reset clears the state register)
    // ------------------------------------------------------------------
    always_comb begin
        Sl_xferAck = (state_q == ACK);
        Sl_DBus    = (state_q == ACK) ? rd_data_q : '0;
        Sl_errAck  = 1'b0;
        Sl_retry   = 1'b0;
        Sl_toutSup = 1'b0;
    end

    // ------------------------------------------------------------------
    // Register bank and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            data_q    <= 32'h0;
            count_q   <= 32'h0;
            freeze_q  <= 1'b0;
            rd_data_q <= 32'h0;
        end else begin
            if (capture) begin
                data_q  <= user_data_in;
                count_q <= count_q + 32'd1;
            end
            if (ctrl_wr) begin
                freeze_q <= OPB_DBus[31];
            end
            // Read data is latched from pre-edge register contents; writes
            // return zero on the bus during their acknowledge.
            if (start) begin
                rd_data_q <= OPB_RNW ? read_mux : 32'h0;
            end
        end
    end

endmodule

// File: doc/opb_register_simulink2ppc_snap.md
# opb_register_simulink2ppc_snap

OPB slave that presents user-fabric data to the PowerPC as a small read-only register bank: a captured 32-bit data word, a capture counter and a freeze control bit. It is the fabric-to-processor counterpart of the processor-to-fabric software register and sits on the same OPB segment, driven by the same clock as the user logic. Every OPB access inside the window is acknowledged exactly once through a registered single-cycle handshake.

## Interface
- C_BASEADDR, 32'h0103C100, first byte address of the window
- C_HIGHADDR, 32'h0103C1FF, last byte address of the window
- C_OPB_AWIDTH, 32, OPB address width
- C_OPB_DWIDTH, 32, OPB data width
- C_FAMILY, "virtex6", target family (informational)

- OPB_Clk  in  1  sole clock for the OPB side and the user side
- OPB_Rst  in  1  reset, asynchronous, active-high
- OPB_ABus  in  [0:31]  byte address
- OPB_BE  in  [0:3]  byte enables; BE[3] covers OPB_DBus[24:31]
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read, 0 = write
- OPB_select  in  1  transfer in progress
- OPB_seqAddr  in  1  ignored
- Sl_DBus  out  [0:31]  read data; all-zero whenever Sl_xferAck is low
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0
- Sl_xferAck  out  1  single-cycle transfer acknowledge
- user_data_in  in  [31:0]  fabric data; bit 31 maps to OPB_DBus[0]
- user_valid  in  1  capture strobe

## Operation
- Address hit: C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Offset is OPB_ABus[24:29] (word index).
- Register map:
  - 0x00 DATA (RO): last captured user_data_in.
  - 0x04 COUNT (RO): 32-bit count of accepted captures; wraps 0xFFFFFFFF -> 0.
  - 0x08 CTRL (RW): bit 0 = freeze; bits 31:1 read 0.
  - 0x0C..0xFC: read 0, writes ignored, still acknowledged.
- Capture: on a clock edge with user_valid=1 and freeze=0, DATA <= user_data_in and COUNT <= COUNT+1. With freeze=1 both hold.
- Writes: only CTRL is writable, and only when BE[3]=1 (freeze <= OPB_DBus[31]). Writes to DATA and COUNT are acknowledged with no effect.
- FSM, three states:
  - IDLE: OPB_select and hit -> ACK.
  - ACK: Sl_xferAck=1 for exactly one cycle, then go to WAIT.
  - WAIT: remain until OPB_select=0, then go to IDLE. Guarantees one ack per select assertion even if the master holds select.
- Reset values: Sl_DBus=0, Sl_xferAck=0, tied outputs 0, DATA=0, COUNT=0, freeze=0, FSM=IDLE.
- Reset mid-transaction: asynchronous clear drops Sl_xferAck and Sl_DBus the same instant, FSM returns to IDLE. A pending access is not acknowledged; the master times out.

## Timing
- Cycle 0 is the first edge that samples OPB_select=1 with a hit.
- Sl_xferAck and Sl_DBus are registered and valid in cycle 1 only (latency 1). Sl_DBus returns register contents as they stood before edge 0's updates.
- Simultaneous user_valid and read in cycle 0: the read returns the old DATA and COUNT; the capture is visible to the next read.
- Simultaneous CTRL write and user_valid: the write commits at the edge that raises Sl_xferAck. A capture at that same edge uses the old freeze value.
- Back-to-back accesses: at least one cycle with OPB_select=0 is required between acks. Minimum transfer is 2 cycles.
- OPB_select falling while in ACK: the ack still completes, and the FSM goes to IDLE through WAIT on the next edge.

## Test plan
- Reset, then read 0x00, 0x04 and 0x08 -> each returns 0x00000000. Sl_xferAck is high exactly 1 cycle after select; Sl_DBus is 0 outside ack.
- Pulse user_valid 3 times with 0xDEADBEEF last -> read 0x00 returns 0xDEADBEEF; read 0x04 returns 3.
- Write 0x00000001 to 0x08 with BE=4'b1111, then pulse user_valid with 0x12345678 -> DATA and COUNT unchanged. Repeat the write with BE=4'b1110 -> freeze unchanged. Write 0 with BE=4'b0001 -> captures resume.
- Preload COUNT to 0xFFFFFFFF via 2^32-1 fast-forwarded captures (force), then one more capture -> read 0x04 returns 0.
- Hold OPB_select high for 6 cycles -> exactly one Sl_xferAck. Address 0x0103C200 (out of window) -> no ack. Read of 0x10 -> ack with data 0.
- Assert OPB_Rst in the ACK cycle -> Sl_xferAck and Sl_DBus are 0 immediately, registers clear, and the next access completes normally.
